// File: rtl/adder_operand_stage.sv
// Purpose: operand/opcode stage feeding the 32-bit Brent-Kung adder. Buffers add-class
//          commands, maps them to in1/in2/carryIn, and owns the architectural carry flag.
// Latency: 1 cycle from accept to out_valid when the buffer is empty (bypass); else FIFO order.
// Backpressure: in_ready = command FIFO not full (registered state only); issue outputs hold
//          while out_valid & !out_ready; ADC/SBC wait for every older carry to come back.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready, in_op/a/b     command input handshake and payload
//   out_valid/out_ready              issue handshake towards the adder
//   add_in1/add_in2/add_cin, out_op  registered adder operands and forwarded opcode tag
//   carry_fb_valid/carry_fb          in-order carry-out return from the result stage
//   c_flag, outstanding              carry flag and count of issued ops awaiting carry
//
// Optional build macro ADDER_OPSTAGE_CARRY_FWD_EN: when defined, an ADC/SBC at the head may
// load in the same cycle the last outstanding carry returns, taking add_cin from carry_fb.

// Generic FIFO: DEPTH-entry (power of 2) first-word-fall-through queue, registered state.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty; full/empty are registered.
module adder_opstage_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr];

  // Storage is not reset; only the pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_rdy) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_vld, pop_rdy})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Operand stage top: command FIFO + registered issue slot + carry flag / outstanding tracking.
// Latency: accept at cycle N gives out_valid at N+1 when the FIFO is empty and issue is allowed.
// Backpressure: in_ready drops when the FIFO is full; nothing is lost or duplicated under stall.
module adder_operand_stage #(
  parameter int WIDTH           = 32,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2:0]                           in_op,
  input  logic [WIDTH-1:0]                     in_a,
  input  logic [WIDTH-1:0]                     in_b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     add_in1,
  output logic [WIDTH-1:0]                     add_in2,
  output logic                                 add_cin,
  output logic [2:0]                           out_op,
  input  logic                                 carry_fb_valid,
  input  logic                                 carry_fb,
  output logic                                 c_flag,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW:0] MAX_V = (CW+1)'(MAX_OUTSTANDING);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t       in_cmd;
  cmd_t       fifo_head;
  cmd_t       head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       live;          // low for the cycle(s) spent in reset, gates in_ready
  logic       accept;
  logic       drain;
  logic       slot_free;
  logic       head_vld;
  logic       under_limit;
  logic       head_dep;
  logic       dep_ok;
  logic       load;
  logic       push;
  logic       pop;
  logic       fb_acc;
  logic       cin_src;
  logic [CW:0] pend;

  logic [WIDTH-1:0] m_in1;
  logic [WIDTH-1:0] m_in2;
  logic             m_cin;

  assign in_cmd    = '{op: in_op, a: in_a, b: in_b};
  assign in_ready  = live & ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // The head is the oldest buffered command, or the incoming one when the FIFO is empty.
  assign head      = fifo_empty ? in_cmd : fifo_head;
  assign head_vld  = ~fifo_empty | accept;
  assign slot_free = ~out_valid | drain;

  // An op sitting in the issue register counts against the limit whether or not it drains
  // this cycle: if it drains it becomes outstanding at the same edge the new op loads.
  assign pend        = {1'b0, outstanding} + {{CW{1'b0}}, out_valid};
  assign under_limit = (pend < MAX_V);

  assign head_dep = (head.op == OP_ADC) | (head.op == OP_SBC);

  // A return with nothing outstanding is a protocol error unless an issue happens alongside.
  assign fb_acc = carry_fb_valid & ((outstanding != '0) | drain);

`ifdef ADDER_OPSTAGE_CARRY_FWD_EN
  logic fwd_hit;
  // Last older carry is arriving right now: issue the dependent op and use it directly.
  assign fwd_hit = carry_fb_valid & (outstanding == CW'(1)) & ~out_valid;
  assign dep_ok  = ~out_valid & ((outstanding == '0) | fwd_hit);
  assign cin_src = fwd_hit ? carry_fb : c_flag;
`else
  // The issue register must be empty too: an op draining now still owes its carry.
  assign dep_ok  = ~out_valid & (outstanding == '0);
  assign cin_src = c_flag;
`endif

  assign load = slot_free & head_vld & under_limit & (~head_dep | dep_ok);
  assign pop  = load & ~fifo_empty;
  assign push = accept & ~(load & fifo_empty);

  adder_opstage_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_dat (in_cmd),
    .pop_rdy  (pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Opcode to adder operand mapping, evaluated on the head at load time.
  always_comb begin
    m_in1 = head.a;
    m_in2 = head.b;
    m_cin = 1'b0;
    case (head.op)
      OP_ADD:  begin m_in1 = head.a;  m_in2 = head.b;   m_cin = 1'b0;    end
      OP_SUB:  begin m_in1 = head.a;  m_in2 = ~head.b;  m_cin = 1'b1;    end
      OP_ADC:  begin m_in1 = head.a;  m_in2 = head.b;   m_cin = cin_src; end
      OP_SBC:  begin m_in1 = head.a;  m_in2 = ~head.b;  m_cin = cin_src; end
      OP_INC:  begin m_in1 = head.a;  m_in2 = '0;       m_cin = 1'b1;    end
      OP_DEC:  begin m_in1 = head.a;  m_in2 = '1;       m_cin = 1'b0;    end
      OP_NEG:  begin m_in1 = '0;      m_in2 = ~head.a;  m_cin = 1'b1;    end
      OP_PASS: begin m_in1 = head.a;  m_in2 = '0;       m_cin = 1'b0;    end
      default: begin m_in1 = head.a;  m_in2 = head.b;   m_cin = 1'b0;    end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live        <= 1'b0;
      out_valid   <= 1'b0;
      add_in1     <= '0;
      add_in2     <= '0;
      add_cin     <= 1'b0;
      out_op      <= 3'b000;
      c_flag      <= 1'b0;
      outstanding <= '0;
    end else begin
      live <= 1'b1;

      if (load) begin
        out_valid <= 1'b1;
        add_in1   <= m_in1;
        add_in2   <= m_in2;
        add_cin   <= m_cin;
        out_op    <= head.op;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (fb_acc) begin
        c_flag <= carry_fb;
      end

      case ({drain, fb_acc})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_operand_stage.sv
// Bench for adder_operand_stage: directed command sequences with hand-computed literal
// expectations, plus a queue-based scoreboard that checks every issue, the carry flag and
// the outstanding count on every cycle out of reset.
module tb_adder_operand_stage;
  localparam int W    = 32;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  add_in1;
  logic [W-1:0]  add_in2;
  logic          add_cin;
  logic [2:0]    out_op;
  logic          carry_fb_valid = 1'b0;
  logic          carry_fb = 1'b0;
  logic          c_flag;
  logic [2:0]    outstanding;

  adder_operand_stage #(.WIDTH(W), .FIFO_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin), .out_op(out_op),
    .carry_fb_valid(carry_fb_valid), .carry_fb(carry_fb),
    .c_flag(c_flag), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  cmd_t        q[$];
  int          mcnt = 0;
  logic        mc = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] p1, p2;
  logic        pc;
  logic [2:0]  pop_;

  // What the adder must see for a command given the architectural carry at issue.
  task automatic model_map(input cmd_t c, input logic carry,
                           output logic [31:0] e1, output logic [31:0] e2, output logic ec);
    case (c.op)
      3'd0: begin e1 = c.a;   e2 = c.b;          ec = 1'b0;  end
      3'd1: begin e1 = c.a;   e2 = ~c.b;         ec = 1'b1;  end
      3'd2: begin e1 = c.a;   e2 = c.b;          ec = carry; end
      3'd3: begin e1 = c.a;   e2 = ~c.b;         ec = carry; end
      3'd4: begin e1 = c.a;   e2 = 32'd0;        ec = 1'b1;  end
      3'd5: begin e1 = c.a;   e2 = 32'hFFFFFFFF; ec = 1'b0;  end
      3'd6: begin e1 = 32'd0; e2 = ~c.a;         ec = 1'b1;  end
      default: begin e1 = c.a; e2 = 32'd0;       ec = 1'b0;  end
    endcase
  endtask

  always @(negedge clk) begin
    logic hs;
    logic fb_ok;
    cmd_t e;
    logic [31:0] e1, e2;
    logic ec;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      mc = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("outstanding", 32'(outstanding), 32'(mcnt));
      chk("c_flag", 32'(c_flag), 32'(mc));
      chk("outstanding_limit", 32'(mcnt <= MAXO), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in1", add_in1, p1);
        chk("hold_in2", add_in2, p2);
        chk("hold_cin", 32'(add_cin), 32'(pc));
        chk("hold_op", 32'(out_op), 32'(pop_));
      end
      hs = out_valid & out_ready;
      if (hs) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL issue_unexpected: got op %0d in1 0x%08h, expected no issue", out_op, add_in1);
        end else begin
          e = q.pop_front();
          model_map(e, mc, e1, e2, ec);
          chk("issue_op", 32'(out_op), 32'(e.op));
          chk("issue_in1", add_in1, e1);
          chk("issue_in2", add_in2, e2);
          chk("issue_cin", 32'(add_cin), 32'(ec));
          if (e.op == 3'd2 || e.op == 3'd3) chk("dep_no_older_pending", 32'(mcnt), 32'd0);
        end
      end
      fb_ok = carry_fb_valid && (mcnt > 0 || hs);
      if (fb_ok) mc = carry_fb;
      if (hs) mcnt++;
      if (fb_ok) mcnt--;
      if (in_valid && in_ready) q.push_back('{op: in_op, a: in_a, b: in_b});
      prev_stall = out_valid & ~out_ready;
      p1 = add_in1; p2 = add_in2; pc = add_cin; pop_ = out_op;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!in_ready && t < 50) begin step(); t++; end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic ret(input logic v);
    carry_fb_valid = 1'b1; carry_fb = v;
    step();
    carry_fb_valid = 1'b0; carry_fb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    // Reset held 3 cycles with a command offered.
    rst_n = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 32'h11; in_b = 32'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_c_flag", 32'(c_flag), 32'd0);
    end
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_add_in1", add_in1, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_no_issue", 32'(out_valid), 32'd0);

    // SUB mapping, one-cycle bypass latency.
    out_ready = 1'b1;
    send(3'd1, 32'h5, 32'h3);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_in1", add_in1, 32'h00000005);
    chk("sub_in2", add_in2, 32'hFFFFFFFC);
    chk("sub_cin", 32'(add_cin), 32'd1);
    chk("sub_op", 32'(out_op), 32'd1);
    step();
    chk("sub_outstanding", 32'(outstanding), 32'd1);
    ret(1'b1);
    chk("sub_ret_cflag", 32'(c_flag), 32'd1);
    chk("sub_ret_outstanding", 32'(outstanding), 32'd0);

    // DEC of zero: carry-out 0 clears the flag.
    send(3'd5, 32'h0, 32'h1234);
    chk("dec_in2", add_in2, 32'hFFFFFFFF);
    chk("dec_cin", 32'(add_cin), 32'd0);
    step();
    ret(1'b0);
    chk("dec_ret_cflag", 32'(c_flag), 32'd0);

    // ADD then dependent ADC; carry returns 3 cycles after the ADD issues.
    send(3'd0, 32'hFFFFFFFF, 32'h1);
    send(3'd2, 32'h1, 32'h2);
    chk("adc_wait0", 32'(out_valid), 32'd0);
    step();
    chk("adc_wait1", 32'(out_valid), 32'd0);
    step();
    chk("adc_wait2", 32'(out_valid), 32'd0);
    ret(1'b1);
`ifdef ADDER_OPSTAGE_CARRY_FWD_EN
    chk("adc_fwd_valid", 32'(out_valid), 32'd1);
`else
    chk("adc_wait3", 32'(out_valid), 32'd0);
    step();
    chk("adc_valid", 32'(out_valid), 32'd1);
`endif
    chk("adc_in1", add_in1, 32'h1);
    chk("adc_in2", add_in2, 32'h2);
    chk("adc_cin", 32'(add_cin), 32'd1);
    chk("adc_op", 32'(out_op), 32'd2);
    step();
    ret(1'b0);

    // Backpressure: register plus FIFO_DEPTH entries fill, then drain in order.
    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20);
    send(3'd1, 32'd7, 32'd9);
    send(3'd7, 32'h1234, 32'hABCD);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_in1", add_in1, 32'd10);
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd7; in_b = 32'd0;
    step();
    chk("bp_in_ready_held", 32'(in_ready), 32'd0);
    chk("bp_hold_in1", add_in1, 32'd10);
    out_ready = 1'b1;
    step();
    chk("bp_second_in1", add_in1, 32'd7);
    chk("bp_second_in2", add_in2, 32'hFFFFFFF6);
    chk("bp_second_cin", 32'(add_cin), 32'd1);
    chk("bp_reopen", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_outstanding", 32'(outstanding), 32'd4);
    repeat (4) ret(1'b0);

    // Outstanding limit: fifth ADD waits for one carry.
    for (int i = 1; i <= 5; i++) send(3'd0, 32'(i * 16), 32'(i));
    step();
    chk("lim_held", 32'(out_valid), 32'd0);
    chk("lim_count", 32'(outstanding), 32'd4);
    ret(1'b1);
    step();
    chk("lim_fifth_valid", 32'(out_valid), 32'd1);
    chk("lim_fifth_in1", add_in1, 32'd80);
    step();
    chk("lim_after", 32'(outstanding), 32'd4);
    repeat (4) ret(1'b1);
    chk("lim_cflag", 32'(c_flag), 32'd1);

    // Reset mid-stream with FIFO holding 2 and outstanding = 3.
    for (int i = 0; i < 3; i++) send(3'd0, 32'h100 + 32'(i), 32'h1);
    step();
    chk("mid_outstanding", 32'(outstanding), 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd4, 32'h200 + 32'(i), 32'h0);
    chk("mid_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    chk("mid_rst_cflag", 32'(c_flag), 32'd0);
    step();
    chk("mid_release_ready", 32'(in_ready), 32'd1);
    chk("mid_no_phantom", 32'(out_valid), 32'd0);
    ret(1'b1);
    chk("stray_fb_outstanding", 32'(outstanding), 32'd0);
    chk("stray_fb_cflag", 32'(c_flag), 32'd0);

    // NEG, SBC, PASS mappings.
    send(3'd6, 32'h1, 32'h0);
    chk("neg_in1", add_in1, 32'h0);
    chk("neg_in2", add_in2, 32'hFFFFFFFE);
    chk("neg_cin", 32'(add_cin), 32'd1);
    step();
    ret(1'b0);
    send(3'd3, 32'h5, 32'h3);
    chk("sbc_in2", add_in2, 32'hFFFFFFFC);
    chk("sbc_cin", 32'(add_cin), 32'd0);
    step();
    ret(1'b1);
    send(3'd7, 32'hDEADBEEF, 32'h55);
    chk("pass_in1", add_in1, 32'hDEADBEEF);
    chk("pass_in2", add_in2, 32'h0);
    chk("pass_cin", 32'(add_cin), 32'd0);
    step();
    ret(1'b0);
    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_outstanding", 32'(outstanding), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
